// File: rtl/pulse_gen.sv
// pulse_gen: programmable pulse-train transmitter.
// Emits num pulses of hi_len cycles high separated by lo_len cycles low,
// reporting progress on sent and completion/abort on a one-cycle done strobe.
// Optional feature macro: PULSE_GEN_CONT_EN (num=0 at start runs continuously
// until stop). Without it, num=0 produces an immediate done and no pulses.
module pulse_gen #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned LEN_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic [CNT_WIDTH-1:0] num,
    input  logic [LEN_WIDTH-1:0] hi_len,
    input  logic [LEN_WIDTH-1:0] lo_len,
    output logic                 d_o,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] sent
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t               state;
    logic [CNT_WIDTH-1:0] num_q;
    logic [LEN_WIDTH-1:0] hi_rl_q;
    logic [LEN_WIDTH-1:0] lo_rl_q;
    logic [LEN_WIDTH-1:0] phase_cnt;

    // Reload values are (length - 1), with a zero length treated as one cycle.
    logic [LEN_WIDTH-1:0] hi_rl;
    logic [LEN_WIDTH-1:0] lo_rl;
    logic                 num_zero;
    logic                 launch;
    logic                 last_pulse;

    assign hi_rl    = (hi_len == '0) ? '0 : hi_len - LEN_WIDTH'(1);
    assign lo_rl    = (lo_len == '0) ? '0 : lo_len - LEN_WIDTH'(1);
    assign num_zero = (num == '0);

`ifdef PULSE_GEN_CONT_EN
    logic cont_q;

    // A continuous train never reaches a last pulse; it ends only on stop.
    assign launch     = start && !stop;
    assign last_pulse = !cont_q && (sent == num_q);

    // Continuous-mode flag, latched with the rest of the configuration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cont_q <= 1'b0;
        end else if (state == IDLE && launch) begin
            cont_q <= num_zero;
        end
    end
`else
    assign launch     = start && !stop && !num_zero;
    assign last_pulse = (sent == num_q);
`endif

    // Pulse-train FSM with registered outputs and phase down-counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            d_o       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sent      <= '0;
            num_q     <= '0;
            hi_rl_q   <= '0;
            lo_rl_q   <= '0;
            phase_cnt <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state     <= HIGH;
                        d_o       <= 1'b1;
                        busy      <= 1'b1;
                        sent      <= CNT_WIDTH'(1);
                        num_q     <= num;
                        hi_rl_q   <= hi_rl;
                        lo_rl_q   <= lo_rl;
                        phase_cnt <= hi_rl;
                    end else if (start && !stop) begin
                        // Zero-length train: report completion without pulsing.
                        done <= 1'b1;
                        sent <= '0;
                    end
                end
                HIGH: begin
                    if (stop) begin
                        state <= IDLE;
                        d_o   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - LEN_WIDTH'(1);
                    end else if (last_pulse) begin
                        state <= IDLE;
                        d_o   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state     <= LOW;
                        d_o       <= 1'b0;
                        phase_cnt <= lo_rl_q;
                    end
                end
                LOW: begin
                    if (stop) begin
                        state <= IDLE;
                        d_o   <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (phase_cnt != '0) begin
                        phase_cnt <= phase_cnt - LEN_WIDTH'(1);
                    end else begin
                        state     <= HIGH;
                        d_o       <= 1'b1;
                        sent      <= sent + CNT_WIDTH'(1);
                        phase_cnt <= hi_rl_q;
                    end
                end
                default: begin
                    state <= IDLE;
                    d_o   <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
